// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program-counter generator with prioritised redirects
// Optional feature macro: PC_RAS_EN (return-address stack for ret prediction).
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   pc_en               advance enable (0 = stall)
//   set_en, set_addr    trap/set redirect request and target
//   br_taken, br_off    taken conditional branch, signed 13-bit offset
//   jmp_valid           resolved JAL/JALR; jmp_is_reg selects JALR
//   jmp_imm, reg_data   JAL offset / JALR immediate, rs1 value for JALR
//   jmp_call, jmp_ret   call / return hints feeding the return-address stack
//   pc_addr             current fetch address
//   redirect            pulse: pc_addr holds a non-sequential target
//   misalign            pulse: that target has bit 1 set
//   ras_hit             pulse: the JALR target came from the return-address stack
module pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              JAL_LAG   = 8,
  parameter int              BR_LAG    = 12,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_en,
  input  logic            set_en,
  input  logic [XLEN-1:0] set_addr,
  input  logic            br_taken,
  input  logic [12:0]     br_off,
  input  logic            jmp_valid,
  input  logic            jmp_is_reg,
  input  logic [20:0]     jmp_imm,
  input  logic [XLEN-1:0] reg_data,
  input  logic            jmp_call,
  input  logic            jmp_ret,
  output logic [XLEN-1:0] pc_addr,
  output logic            redirect,
  output logic            misalign,
  output logic            ras_hit
);

  localparam logic [XLEN-1:0] JAL_LAG_V = XLEN'(JAL_LAG);
  localparam logic [XLEN-1:0] BR_LAG_V  = XLEN'(BR_LAG);
  localparam logic [XLEN-1:0] STEP_V    = XLEN'(4);
  localparam logic [XLEN-1:0] LSB_MASK  = ~XLEN'(1);

  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jal_target;
  logic [XLEN-1:0] jalr_calc;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] next_pc;
  logic            take_set;
  logic            take_br;
  logic            take_jmp;
  logic            take_jal;
  logic            take_jalr;
  logic            take_seq;
  logic            take_redir;

  // Fixed priority: set > branch > jump > sequential. A branch is taken even
  // while stalled because the execute stage has already committed to it.
  assign take_set   = set_en & pc_en;
  assign take_br    = br_taken & ~take_set;
  assign take_jmp   = jmp_valid & pc_en & ~take_set & ~br_taken;
  assign take_jal   = take_jmp & ~jmp_is_reg;
  assign take_jalr  = take_jmp & jmp_is_reg;
  assign take_seq   = pc_en & ~take_set & ~br_taken & ~jmp_valid;
  assign take_redir = take_set | take_br | take_jmp;

  // PC-relative targets are resolved in execute while fetch has run ahead,
  // so the lag constants pull them back to the jumping instruction.
  assign br_target  = pc_addr + {{(XLEN-13){br_off[12]}}, br_off} - BR_LAG_V;
  assign jal_target = pc_addr + {{(XLEN-21){jmp_imm[20]}}, jmp_imm} - JAL_LAG_V;
  assign jalr_calc  = (reg_data + {{(XLEN-12){jmp_imm[11]}}, jmp_imm[11:0]}) & LSB_MASK;

`ifdef PC_RAS_EN
  localparam int               PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int               CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] push_idx;
  logic [CNT_W-1:0] ras_cnt;
  logic             ras_push;
  logic             ras_pop;
  logic [XLEN-1:0]  ras_push_val;
  logic             ras_hit_q;

  // ras_ptr is the next free slot; the top of stack sits one below it.
  assign top_ptr      = ras_ptr - PTR_W'(1);
  assign ras_pop      = take_jalr & jmp_ret & (ras_cnt != '0);
  assign ras_push     = take_jmp & jmp_call;
  assign ras_push_val = pc_addr - JAL_LAG_V + STEP_V;
  // A coroutine swap pops then pushes, so the new entry replaces the top.
  assign push_idx     = ras_pop ? top_ptr : ras_ptr;
  assign jalr_target  = ras_pop ? (ras_mem[top_ptr] & LSB_MASK) : jalr_calc;
  assign ras_hit      = ras_hit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr   <= '0;
      ras_cnt   <= '0;
      ras_hit_q <= 1'b0;
    end else begin
      ras_hit_q <= ras_pop;
      if (ras_pop && !ras_push) begin
        ras_ptr <= top_ptr;
        ras_cnt <= ras_cnt - CNT_W'(1);
      end else if (ras_push && !ras_pop) begin
        // When full the pointer wraps onto the oldest entry and overwrites it.
        ras_ptr <= ras_ptr + PTR_W'(1);
        if (ras_cnt != CNT_MAX) begin
          ras_cnt <= ras_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Entry contents need no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem[push_idx] <= ras_push_val;
    end
  end
`else
  logic unused_ras;

  assign unused_ras  = jmp_call ^ jmp_ret ^ (RAS_DEPTH > 1);
  assign jalr_target = jalr_calc;
  assign ras_hit     = 1'b0;
`endif

  always_comb begin
    next_pc = pc_addr;
    if (take_set) begin
      next_pc = set_addr;
    end else if (take_br) begin
      next_pc = br_target;
    end else if (take_jal) begin
      next_pc = jal_target;
    end else if (take_jalr) begin
      next_pc = jalr_target;
    end else if (take_seq) begin
      next_pc = pc_addr + STEP_V;
    end
  end

  // Status pulses are registered with the PC so they line up with the new address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_addr  <= RESET_VEC;
      redirect <= 1'b0;
      misalign <= 1'b0;
    end else begin
      pc_addr  <= next_pc;
      redirect <= take_redir;
      misalign <= take_redir & next_pc[1];
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard testbench for pc_unit
module tb_pc_unit;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        red;
    logic        mis;
    logic        hit;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_en;
  logic        set_en;
  logic [31:0] set_addr;
  logic        br_taken;
  logic [12:0] br_off;
  logic        jmp_valid;
  logic        jmp_is_reg;
  logic [20:0] jmp_imm;
  logic [31:0] reg_data;
  logic        jmp_call;
  logic        jmp_ret;
  logic [31:0] pc_addr;
  logic        redirect;
  logic        misalign;
  logic        ras_hit;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  pc_unit #(
    .XLEN(32), .RESET_VEC(32'h100), .JAL_LAG(8), .BR_LAG(12), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .set_en(set_en), .set_addr(set_addr),
    .br_taken(br_taken), .br_off(br_off), .jmp_valid(jmp_valid),
    .jmp_is_reg(jmp_is_reg), .jmp_imm(jmp_imm), .reg_data(reg_data),
    .jmp_call(jmp_call), .jmp_ret(jmp_ret), .pc_addr(pc_addr),
    .redirect(redirect), .misalign(misalign), .ras_hit(ras_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic idle();
    pc_en = 0; set_en = 0; set_addr = 0; br_taken = 0; br_off = 0;
    jmp_valid = 0; jmp_is_reg = 0; jmp_imm = 0; reg_data = 0;
    jmp_call = 0; jmp_ret = 0;
  endtask

  // Drive one cycle of inputs at the falling edge and queue the state
  // expected right after the following rising edge.
  task automatic cyc(input string nm, input logic pe, input logic se, input logic [31:0] sa,
                     input logic bt, input logic [12:0] bo, input logic jv, input logic jr,
                     input logic [20:0] ji, input logic [31:0] rd, input logic jc, input logic jt,
                     input logic [31:0] e_pc, input logic e_red, input logic e_mis, input logic e_hit);
    exp_t e;
    @(negedge clk);
    pc_en = pe; set_en = se; set_addr = sa; br_taken = bt; br_off = bo;
    jmp_valid = jv; jmp_is_reg = jr; jmp_imm = ji; reg_data = rd;
    jmp_call = jc; jmp_ret = jt;
    e.name = nm; e.pc = e_pc; e.red = e_red; e.mis = e_mis; e.hit = e_hit;
    exp_q.push_back(e);
  endtask

  task automatic seq(input string nm, input logic [31:0] e_pc);
    cyc(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_pc, 0, 0, 0);
  endtask

  task automatic set_pc(input string nm, input logic [31:0] a, input logic e_mis);
    cyc(nm, 1, 1, a, 0, 0, 0, 0, 0, 0, 0, 0, a, 1, e_mis, 0);
  endtask

  // Monitor: compares every sampled cycle that has an expectation queued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, ".pc"}, pc_addr, mon_e.pc);
        check({mon_e.name, ".redirect"}, 32'(redirect), 32'(mon_e.red));
        check({mon_e.name, ".misalign"}, 32'(misalign), 32'(mon_e.mis));
        check({mon_e.name, ".ras_hit"}, 32'(ras_hit), 32'(mon_e.hit));
      end
    end
  end

  initial begin
    rst = 0;
    idle();
    #1 rst = 1;
    #3;
    check("reset.pc", pc_addr, 32'h100);
    check("reset.redirect", 32'(redirect), 0);
    check("reset.misalign", 32'(misalign), 0);
    check("reset.ras_hit", 32'(ras_hit), 0);
    @(negedge clk) rst = 0;

    seq("seq1", 32'h104);
    seq("seq2", 32'h108);
    seq("seq3", 32'h10C);
    set_pc("set40", 32'h40, 0);
    cyc("br_stalled", 0, 0, 0, 1, 13'h1FF8, 0, 0, 0, 0, 0, 0, 32'h2C, 1, 0, 0);
    cyc("hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2C, 0, 0, 0);
    set_pc("set200", 32'h200, 0);
    cyc("prio_set", 1, 1, 32'h800, 1, 13'h010, 1, 0, 21'h100, 0, 0, 0, 32'h800, 1, 0, 0);
    cyc("prio_br", 1, 0, 0, 1, 13'h020, 1, 0, 21'h40, 0, 0, 0, 32'h814, 1, 0, 0);
    cyc("jal_mis", 1, 0, 0, 0, 0, 1, 0, 21'h2, 0, 0, 0, 32'h80E, 1, 1, 0);
    cyc("jal_neg", 1, 0, 0, 0, 0, 1, 0, 21'h1FFFF2, 0, 0, 0, 32'h7F8, 1, 0, 0);
    cyc("jalr_mis", 1, 0, 0, 0, 0, 1, 1, 21'h0AFFF, 32'h1003, 0, 0, 32'h1002, 1, 1, 0);
    cyc("jalr_ret_empty", 1, 0, 0, 0, 0, 1, 1, 21'h010, 32'h2000, 0, 1, 32'h2010, 1, 0, 0);
    cyc("jmp_stalled", 0, 0, 0, 0, 0, 1, 1, 21'h010, 32'h5000, 0, 0, 32'h2010, 0, 0, 0);
    cyc("set_stall1", 0, 1, 32'h3006, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2010, 0, 0, 0);
    cyc("set_stall2", 0, 1, 32'h3006, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2010, 0, 0, 0);
    cyc("set_accept", 1, 1, 32'h3006, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3006, 1, 1, 0);
    seq("seq_after_mis", 32'h300A);
    set_pc("set_top", 32'hFFFF_FFFC, 0);
    seq("wrap", 32'h0);
    cyc("br_active", 1, 0, 0, 1, 13'h0010, 0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0);

`ifdef PC_RAS_EN
    for (int i = 1; i <= 5; i++) begin
      set_pc("ras_set", 32'(i * 16), 0);
      cyc("ras_call", 1, 0, 0, 0, 0, 1, 0, 21'h010, 0, 1, 0, 32'(i * 16 + 8), 1, 0, 0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc("ras_ret", 1, 0, 0, 0, 0, 1, 1, 21'h0, 32'h900, 0, 1, 32'(32'h4C - k * 16), 1, 0, 1);
    end
    cyc("ras_ret_empty", 1, 0, 0, 0, 0, 1, 1, 21'h0, 32'h900, 0, 1, 32'h900, 1, 0, 0);
`endif

    // Reset during a redirect pulse clears state without a clock edge.
    set_pc("set_pre_rst", 32'h600, 0);
    @(posedge clk);
    #2;
    idle();
    rst = 1;
    #1;
    check("rst_redirect.pc", pc_addr, 32'h100);
    check("rst_redirect.redirect", 32'(redirect), 0);
    @(negedge clk) rst = 0;

    // Reset during a stall with a set request pending.
    set_pc("set_pre_stall", 32'h640, 0);
    cyc("stall_hold", 0, 1, 32'h700, 0, 0, 0, 0, 0, 0, 0, 0, 32'h640, 0, 0, 0);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("rst_stall.pc", pc_addr, 32'h100);
    cyc("rst_held", 1, 1, 32'h700, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0);
    @(posedge clk);
    #2;
    idle();
    @(negedge clk) rst = 0;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter generator for the in-order RISC-V core. It produces the fetch address each cycle and resolves redirects from four sources in fixed priority: trap/set, conditional branch, JAL/JALR, and sequential +4. Redirect targets computed by the execute stage are corrected by configurable pipeline-lag constants. The block reports misaligned targets and pulses a flush strobe on every redirect; an optional return-address stack predicts `ret` targets.

## Interface
- `XLEN`, 32: address width.
- `RESET_VEC`, 0: value loaded into `pc_addr` by reset.
- `JAL_LAG`, 8: bytes subtracted from PC-relative jump targets (fetch lead at jump resolution).
- `BR_LAG`, 12: bytes subtracted from branch targets.
- `RAS_DEPTH`, 4: return-address-stack entries (power of two, ≥2); ignored unless `PC_RAS_EN` is defined.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_en`  in  1  advance enable (stall when 0).
- `set_en`  in  1  trap/set redirect request.
- `set_addr`  in  XLEN  trap/set target.
- `br_taken`  in  1  conditional branch taken.
- `br_off`  in  13  branch offset, signed.
- `jmp_valid`  in  1  JAL/JALR resolved.
- `jmp_is_reg`  in  1  1 = JALR, 0 = JAL.
- `jmp_imm`  in  21  JAL offset (signed, 21 bits) or JALR immediate (bits [11:0], signed).
- `reg_data`  in  XLEN  rs1 value for JALR.
- `jmp_call`  in  1  jump is a call (rd = x1/x5).
- `jmp_ret`  in  1  JALR is a return (rs1 = x1/x5, rd = x0).
- `pc_addr`  out  XLEN  current fetch address.
- `redirect`  out  1  one-cycle pulse: `pc_addr` just loaded a non-sequential target.
- `misalign`  out  1  one-cycle pulse: loaded target had bit 1 set.
- `ras_hit`  out  1  one-cycle pulse: last JALR target came from the RAS.

## Operation
- Priority per cycle, highest first:
  1. `set_en && pc_en`: `pc_addr <= set_addr`.
  2. `br_taken` (independent of `pc_en`): `pc_addr <= pc_addr + sext(br_off) - BR_LAG`.
  3. `jmp_valid && pc_en`, JAL: `pc_addr <= pc_addr + sext(jmp_imm) - JAL_LAG`.
  4. `jmp_valid && pc_en`, JALR: `pc_addr <= (reg_data + sext(jmp_imm[11:0])) & ~1`.
  5. `pc_en`: `pc_addr <= pc_addr + 4`.
  6. Otherwise hold.
- All arithmetic modulo 2^XLEN; sign extension from bit 12 (branch), bit 20 (JAL), bit 11 (JALR).
- `set_en` with `pc_en` = 0 is ignored; upstream holds it until accepted.
- `redirect` is asserted the cycle after cases 1–4; `misalign` the cycle after any case 1–4 whose loaded target has bit 1 = 1. The PC is still loaded (trap raised downstream).
- Lower-priority requests in the same cycle are dropped; they are not queued.

## Timing
- Reset: `pc_addr` = `RESET_VEC`, `redirect` = `misalign` = `ras_hit` = 0, RAS empty (count 0, pointer 0). Reset asserted mid-stall or mid-redirect overrides everything immediately.
- Latency: one cycle from request to new `pc_addr`; status pulses coincide with the new `pc_addr` value.
- Back-to-back redirects on consecutive cycles are each applied; the second uses the first's result as `pc_addr`.

## Configuration
- `PC_RAS_EN` defined: `RAS_DEPTH`-entry circular return-address stack.
  - Push on an accepted JAL/JALR with `jmp_call`: value = `pc_addr - JAL_LAG + 4` (return address of the jump). When full, overwrite the oldest entry (count saturates at `RAS_DEPTH`, pointer wraps).
  - Pop on an accepted JALR with `jmp_ret` and count > 0: target = popped entry (bit 0 cleared), `ras_hit` pulses. Count = 0: computed JALR target, no pulse.
  - `jmp_call` and `jmp_ret` together (coroutine swap): pop then push, count unchanged.
  - Requests dropped by a higher-priority source do not touch the RAS. `set_en` does not clear the RAS.
- Not defined: no RAS storage, `jmp_call`/`jmp_ret` ignored, `ras_hit` tied 0, JALR always uses the computed target.

## Test plan
- Reset with `RESET_VEC`=0x100, then `pc_en`=1 for 3 cycles -> `pc_addr` 0x100, 0x104, 0x108, 0x10C; all pulses 0.
- `pc_addr`=0x40, `br_taken`=1, `br_off`=0x1FF8 (-8), `pc_en`=0 -> `pc_addr`=0x2C, `redirect`=1 for one cycle.
- `pc_addr`=0x200, `set_en`=1, `br_taken`=1, `jmp_valid`=1, `pc_en`=1, `set_addr`=0x800 -> `pc_addr`=0x800; branch and jump dropped.
- JALR `reg_data`=0x1003, `jmp_imm`=0xFFF (-1) -> `pc_addr`=0x1002, `misalign`=1, `redirect`=1.
- `PC_RAS_EN`, depth 4: five calls from `pc_addr` 0x10, 0x20, 0x30, 0x40, 0x50 (JAL_LAG=8), then five returns -> targets 0x4C, 0x3C, 0x2C, 0x1C with `ras_hit`=1, fifth return uses computed target with `ras_hit`=0.
- `set_en`=1, `pc_en`=0 for 2 cycles, then `pc_en`=1 -> PC holds, then loads `set_addr`; assert `rst` during the stall -> `pc_addr`=`RESET_VEC` with no clock edge.
